// File: rtl/nfc_cmd_queue.sv
// Command sequencer in front of the NAND flash controller: a small FIFO of 33-bit
// transfer commands, issued one at a time off the NFC done pulse. Optional push check: NFC_CMD_CHECK_EN.
module nfc_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [32:0]   push_cmd,
    output logic          push_ready,
    output logic [32:0]   cmd,
    input  logic          done,
    output logic          busy,
    output logic [AW:0]   level,
    output logic [7:0]    issued_cnt,
    output logic          cmd_err
);

    localparam int unsigned CW = 33;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned NW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cmd_q, cmd_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            accept;
    logic            reject;
    logic            enq;
    logic            issue;

`ifdef NFC_CMD_CHECK_EN
    logic [6:0]      len;
    logic [7:0]      span;
    // A transfer must be non-empty and stay inside the 128-byte internal memory.
    always_comb begin
        len    = push_cmd[6:0];
        span   = 8'(push_cmd[13:7]) + 8'(len);
        reject = (len == 7'd0) || (span > 8'd128);
    end
`else
    assign reject = 1'b0;
`endif

    // Next-state: handshake, issue decision, pointer/level/counter updates.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        issue    = 1'b0;
        accept   = push_valid & ready_q;
        enq      = accept & ~reject;

        case (state_q)
            ST_READY: issue = (level_q != '0);
            default: begin
                if (done) begin
                    if (level_q != '0) begin
                        issue = 1'b1;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
        endcase

        if (issue) begin
            cmd_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q + NW'(1);
            state_d  = ST_BUSY;
        end

        if (enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({enq, issue})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        ready_d = (level_d != LW'(DEPTH));
        busy_d  = (state_d == ST_BUSY);
        err_d   = accept & reject;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    assign push_ready = ready_q;
    assign cmd        = cmd_q;
    assign busy       = busy_q;
    assign level      = level_q;
    assign issued_cnt = cnt_q;
    assign cmd_err    = err_q;

endmodule

// File: tb/tb_nfc_cmd_queue.sv
// Directed table-driven bench for nfc_cmd_queue, plus hand sequences for counter
// wrap and the push-check option (NFC_CMD_CHECK_EN).
module tb_nfc_cmd_queue;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic [32:0] push_cmd;
    logic        push_ready;
    logic [32:0] cmd;
    logic        done;
    logic        busy;
    logic [2:0]  level;
    logic [7:0]  issued_cnt;
    logic        cmd_err;

    int errors = 0;
    int checks = 0;

    nfc_cmd_queue #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_cmd   (push_cmd),
        .push_ready (push_ready),
        .cmd        (cmd),
        .done       (done),
        .busy       (busy),
        .level      (level),
        .issued_cnt (issued_cnt),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          gap;
        logic        rst;
        logic        pv;
        logic [32:0] pc;
        logic        dn;
        logic [32:0] ecmd;
        logic [2:0]  elvl;
        logic        erdy;
        logic        ebusy;
        logic [7:0]  ecnt;
    } vec_t;

    localparam logic [32:0] P0 = 33'h0_0001_0040;
    localparam logic [32:0] CA = 33'h1_AAAA_8005;
    localparam logic [32:0] CB = 33'h0_5555_4011;
    localparam logic [32:0] CC = 33'h1_0F0F_C123;
    localparam logic [32:0] CD = 33'h0_F0F0_0201;
    localparam logic [32:0] CE = 33'h1_1111_0001;
`ifdef NFC_CMD_CHECK_EN
    localparam logic [32:0] CS = 33'h1_0000_0081;
`else
    localparam logic [32:0] CS = 33'h1_0000_0080;
`endif

    function automatic vec_t v(int gap, logic r, logic pv, logic [32:0] pc, logic dn,
                               logic [32:0] ecmd, logic [2:0] elvl, logic erdy,
                               logic ebusy, logic [7:0] ecnt);
        vec_t t;
        t.gap = gap; t.rst = r; t.pv = pv; t.pc = pc; t.dn = dn;
        t.ecmd = ecmd; t.elvl = elvl; t.erdy = erdy; t.ebusy = ebusy; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic pv, input logic [32:0] pc, input logic dn);
        rst = r; push_valid = pv; push_cmd = pc; done = dn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    logic [7:0]  exp_cnt;
    logic [32:0] wcmd;

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0);

        // reset, with push/done active during reset to show they are ignored
        tbl.push_back(v(0, 0, 0, '0, 0,  '0, 3'd0, 1, 0, 8'd0));
        tbl.push_back(v(0, 0, 1, CA, 1,  '0, 3'd0, 1, 0, 8'd0));
        // basic issue from IDLE
        tbl.push_back(v(0, 1, 1, P0, 0,  '0, 3'd1, 1, 0, 8'd0));
        tbl.push_back(v(0, 1, 0, '0, 1,  P0, 3'd0, 1, 1, 8'd1));
        // fill to full, fifth push dropped
        tbl.push_back(v(0, 1, 1, CA, 0,  P0, 3'd1, 1, 1, 8'd1));
        tbl.push_back(v(0, 1, 1, CB, 0,  P0, 3'd2, 1, 1, 8'd1));
        tbl.push_back(v(0, 1, 1, CC, 0,  P0, 3'd3, 1, 1, 8'd1));
        tbl.push_back(v(0, 1, 1, CD, 0,  P0, 3'd4, 0, 1, 8'd1));
        tbl.push_back(v(0, 1, 1, CE, 0,  P0, 3'd4, 0, 1, 8'd1));
        // drain in order, done pulses 20 cycles apart
        tbl.push_back(v(0,  1, 0, '0, 1, CA, 3'd3, 1, 1, 8'd2));
        tbl.push_back(v(19, 1, 0, '0, 1, CB, 3'd2, 1, 1, 8'd3));
        tbl.push_back(v(19, 1, 0, '0, 1, CC, 3'd1, 1, 1, 8'd4));
        tbl.push_back(v(19, 1, 0, '0, 1, CD, 3'd0, 1, 1, 8'd5));
        tbl.push_back(v(19, 1, 0, '0, 1, CD, 3'd0, 1, 0, 8'd5));
        // done in READY ignored; starved NFC picks up a push one cycle later
        tbl.push_back(v(0, 1, 0, '0, 1,  CD, 3'd0, 1, 0, 8'd5));
        tbl.push_back(v(0, 1, 1, CS, 0,  CD, 3'd1, 1, 0, 8'd5));
        tbl.push_back(v(0, 1, 0, '0, 0,  CS, 3'd0, 1, 1, 8'd6));
        // mid-operation reset: 3 queued, 1 outstanding
        tbl.push_back(v(0, 1, 1, CA, 0,  CS, 3'd1, 1, 1, 8'd6));
        tbl.push_back(v(0, 1, 1, CB, 0,  CS, 3'd2, 1, 1, 8'd6));
        tbl.push_back(v(0, 1, 1, CC, 0,  CS, 3'd3, 1, 1, 8'd6));
        tbl.push_back(v(0, 0, 0, '0, 0,  '0, 3'd0, 1, 0, 8'd0));
        tbl.push_back(v(0, 1, 0, '0, 1,  '0, 3'd0, 1, 0, 8'd0));
        tbl.push_back(v(0, 1, 0, '0, 0,  '0, 3'd0, 1, 0, 8'd0));
        // simultaneous push and pop keeps level
        tbl.push_back(v(0, 1, 1, CA, 0,  '0, 3'd1, 1, 0, 8'd0));
        tbl.push_back(v(0, 1, 1, CB, 0,  CA, 3'd1, 1, 1, 8'd1));
        tbl.push_back(v(0, 1, 0, '0, 1,  CB, 3'd0, 1, 1, 8'd2));
        // push while full and popping is dropped
        tbl.push_back(v(0, 1, 1, CA, 0,  CB, 3'd1, 1, 1, 8'd2));
        tbl.push_back(v(0, 1, 1, CB, 0,  CB, 3'd2, 1, 1, 8'd2));
        tbl.push_back(v(0, 1, 1, CC, 0,  CB, 3'd3, 1, 1, 8'd2));
        tbl.push_back(v(0, 1, 1, CD, 0,  CB, 3'd4, 0, 1, 8'd2));
        tbl.push_back(v(0, 1, 1, CE, 1,  CA, 3'd3, 1, 1, 8'd3));
        tbl.push_back(v(0, 1, 0, '0, 1,  CB, 3'd2, 1, 1, 8'd4));
        tbl.push_back(v(0, 1, 0, '0, 1,  CC, 3'd1, 1, 1, 8'd5));
        tbl.push_back(v(0, 1, 0, '0, 1,  CD, 3'd0, 1, 1, 8'd6));
        tbl.push_back(v(0, 1, 0, '0, 1,  CD, 3'd0, 1, 0, 8'd6));

        foreach (tbl[i]) begin
            for (int g = 0; g < tbl[i].gap; g++) begin
                drive(1'b1, 1'b0, '0, 1'b0);
                step();
            end
            drive(tbl[i].rst, tbl[i].pv, tbl[i].pc, tbl[i].dn);
            step();
            check($sformatf("row%0d.cmd", i),   64'(cmd),        64'(tbl[i].ecmd));
            check($sformatf("row%0d.level", i), 64'(level),      64'(tbl[i].elvl));
            check($sformatf("row%0d.ready", i), 64'(push_ready), 64'(tbl[i].erdy));
            check($sformatf("row%0d.busy", i),  64'(busy),       64'(tbl[i].ebusy));
            check($sformatf("row%0d.cnt", i),   64'(issued_cnt), 64'(tbl[i].ecnt));
            check($sformatf("row%0d.err", i),   64'(cmd_err),    64'(1'b0));
        end

        // issued_cnt wraps 255 -> 0: one push then one done per iteration
        exp_cnt = 8'd6;
        for (int i = 0; i < 252; i++) begin
            wcmd = {1'b0, 18'(i + 1), 7'd3, 7'd9};
            drive(1'b1, 1'b1, wcmd, 1'b0);
            step();
            drive(1'b1, 1'b0, '0, 1'b1);
            step();
            exp_cnt = exp_cnt + 8'd1;
            check($sformatf("wrap%0d.cnt", i), 64'(issued_cnt), 64'(exp_cnt));
            check($sformatf("wrap%0d.cmd", i), 64'(cmd),        64'(wcmd));
        end

        // reset, then reach READY for the push-check sequences
        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        drive(1'b1, 1'b0, '0, 1'b1);
        step();
        check("chk.level0", 64'(level), 64'(0));

`ifdef NFC_CMD_CHECK_EN
        drive(1'b1, 1'b1, {1'b0, 18'h0, 7'd120, 7'd16}, 1'b0);
        step();
        check("chk.bad1.err",   64'(cmd_err),    64'(1));
        check("chk.bad1.level", 64'(level),      64'(0));
        check("chk.bad1.ready", 64'(push_ready), 64'(1));
        drive(1'b1, 1'b1, {1'b0, 18'h3, 7'd5, 7'd0}, 1'b0);
        step();
        check("chk.bad2.err",   64'(cmd_err), 64'(1));
        check("chk.bad2.level", 64'(level),   64'(0));
        drive(1'b1, 1'b1, {1'b0, 18'h7, 7'd64, 7'd64}, 1'b0);
        step();
        check("chk.good.err",   64'(cmd_err), 64'(0));
        check("chk.good.level", 64'(level),   64'(1));
        drive(1'b1, 1'b0, '0, 1'b0);
        step();
        check("chk.good.cmd",   64'(cmd), 64'({1'b0, 18'h7, 7'd64, 7'd64}));
        check("chk.idle.err",   64'(cmd_err), 64'(0));
`else
        drive(1'b1, 1'b1, {1'b0, 18'h0, 7'd120, 7'd16}, 1'b0);
        step();
        check("nochk.err",   64'(cmd_err), 64'(0));
        check("nochk.level", 64'(level),   64'(1));
        drive(1'b1, 1'b0, '0, 1'b0);
        step();
        check("nochk.cmd",   64'(cmd), 64'({1'b0, 18'h0, 7'd120, 7'd16}));
        check("nochk.cnt",   64'(issued_cnt), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nfc_cmd_queue.md
Name: nfc_cmd_queue

Overview:
- Command sequencer directly upstream of the NAND flash controller (NFC).
- Buffers 33-bit flash transfer commands from the host side in a small FIFO and presents them one at a time on the NFC `cmd` input.
- Paces issue off the NFC `done` pulse. This replaces the ad-hoc "drive next cmd on done" logic with a synthesizable block.
- Command format: bit32 = 1 read flash→memory, 0 write memory→flash; [31:14] flash address; [13:7] internal memory address; [6:0] length in bytes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- push_valid  in  1  host offers a command this cycle.
- push_cmd  in  33  command offered.
- push_ready  out  1  queue can accept; equals ~full.
- cmd  out  33  command to NFC; registered, held stable between issues.
- done  in  1  single-cycle pulse from NFC: ready for next command / previous command finished.
- busy  out  1  a command is outstanding at the NFC (state BUSY).
- level  out  AW+1  number of queued entries.
- issued_cnt  out  8  commands issued since reset; wraps 255→0.
- cmd_err  out  1  one-cycle pulse on a rejected push (optional feature only).

Behaviour:
- Reset (rst==0 at a clk edge) sets: cmd=0, state IDLE, FIFO empty (level=0), push_ready=1, busy=0, issued_cnt=0, cmd_err=0.
- Reset mid-operation flushes all queued entries; the outstanding NFC command is forgotten.
- Push:
  - Accepted when push_valid & push_ready; written at the tail on that edge.
  - level increments on the following cycle.
  - push_valid while full: ignored, no state change.
- FSM, states IDLE, READY, BUSY:
  - IDLE: NFC has not yet signalled ready after reset.
  - READY: NFC idle, queue was empty.
  - BUSY: command outstanding.
- Issue event, on an edge where any of the following holds and the FIFO is non-empty:
  - done==1 in IDLE;
  - done==1 in BUSY;
  - state==READY.
- On an issue event: cmd<=head, pop, issued_cnt+1, next state BUSY.
- On done==1 in IDLE or BUSY with the FIFO empty: next state READY, cmd unchanged.
- done==1 in READY: ignored.
- Latency:
  - done pulse with a non-empty queue → new cmd visible the cycle after that edge.
  - Push into an empty queue while READY → cmd updated at the edge after the push edge (no bypass; 1-cycle latency).
- Simultaneous push and pop: level unchanged; push accepted only if not full at the start of the cycle.
- Pointers are AW bits and wrap modulo DEPTH; full = (level==DEPTH), empty = (level==0).
- cmd retains the last issued value indefinitely; the NFC samples it after done.

Optional Feature:
- Macro: NFC_CMD_CHECK_EN.
- Defined:
  - An accepted push is rejected, not enqueued, if length==0 or {1'b0,mem_addr}+length > 128, computed in 8 bits.
  - Rejection pulses cmd_err for exactly one cycle after the push edge.
  - push_ready is unaffected; the handshake still completes.
- Undefined: every accepted push is enqueued; cmd_err tied 0.

Test Plan:
- Reset then check outputs: hold rst=0 for 2 cycles → cmd=0, level=0, push_ready=1, busy=0, issued_cnt=0.
- Basic issue:
  - Stimulus: push 33'h0_0001_0040 (write, flash 0x00004, mem 0, len 64), then done pulse.
  - Response: cmd=33'h0_0001_0040 one cycle after done; busy=1; issued_cnt=1; level=0.
- Fill and order:
  - Stimulus: push 4 distinct commands with done low, then a 5th push.
  - Response: push_ready=0 when level=4; 5th push ignored.
  - Then 4 done pulses 20 cycles apart → cmds issued in push order; state READY after the 4th done.
- Starved NFC:
  - Stimulus: done pulse with empty queue, then push 33'h1_0000_0080 (read, len 0… under CHECK undefined).
  - Response: cmd updates 1 cycle after push edge without another done.
- Mid-operation reset: 3 queued, 1 outstanding, rst=0 → level=0, cmd=0, state IDLE; a subsequent done does not issue a stale command.
- NFC_CMD_CHECK_EN:
  - Stimulus: push mem 120 len 16, then push len 0.
  - Response: both rejected, cmd_err pulses twice, level stays 0.
  - mem 64 len 64 → accepted.
